// File: rtl/wire_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// wire_scoreboard_pkg
// Shared types and helpers for the wire_scoreboard block:
//   scb_state_t : run-control FSM state encoding (IDLE / RUN / DONE)
//   SCB_MAX_W   : widest counter the saturating helper supports
//   sat_inc     : saturating increment for a counter of a given width
// -----------------------------------------------------------------------------
package wire_scoreboard_pkg;

  typedef enum logic [1:0] {
    SCB_IDLE = 2'b00,
    SCB_RUN  = 2'b01,
    SCB_DONE = 2'b10
  } scb_state_t;

  localparam int unsigned SCB_MAX_W = 64;

  // Increment value by one, holding at the all-ones value of a cnt_w-bit
  // counter. The value is carried zero-extended in a SCB_MAX_W-bit container.
  function automatic logic [SCB_MAX_W-1:0] sat_inc(input logic [SCB_MAX_W-1:0] value,
                                                   input int unsigned           cnt_w);
    logic [SCB_MAX_W-1:0] max_val;
    max_val = (cnt_w >= SCB_MAX_W) ? '1
                                   : ((SCB_MAX_W'(1) << cnt_w) - SCB_MAX_W'(1));
    return (value >= max_val) ? max_val : value + SCB_MAX_W'(1);
  endfunction

endpackage

// File: rtl/wire_scoreboard_if.sv
// -----------------------------------------------------------------------------
// wire_scoreboard_if
// Bundles the sample stream and the statistics of one scoreboard.
//   stimulus : start, stop, sample_en, ref_vec, dut_vec, care_mask
//   results  : running, done, mismatch, samples, errors, first_err_idx,
//              first_err_valid, bit_errors (WIDTH*CNT_W, bit i at [i*CNT_W +: CNT_W])
// Modports: master drives stimulus and reads results; slave is the scoreboard.
// -----------------------------------------------------------------------------
interface wire_scoreboard_if #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 32
);
  logic                   start;
  logic                   stop;
  logic                   sample_en;
  logic [WIDTH-1:0]       ref_vec;
  logic [WIDTH-1:0]       dut_vec;
  logic [WIDTH-1:0]       care_mask;
  logic                   running;
  logic                   done;
  logic                   mismatch;
  logic [CNT_W-1:0]       samples;
  logic [CNT_W-1:0]       errors;
  logic [CNT_W-1:0]       first_err_idx;
  logic                   first_err_valid;
  logic [WIDTH*CNT_W-1:0] bit_errors;

  modport master (
    output start, stop, sample_en, ref_vec, dut_vec, care_mask,
    input  running, done, mismatch, samples, errors, first_err_idx,
           first_err_valid, bit_errors
  );

  modport slave (
    input  start, stop, sample_en, ref_vec, dut_vec, care_mask,
    output running, done, mismatch, samples, errors, first_err_idx,
           first_err_valid, bit_errors
  );
endinterface

// File: rtl/wire_scoreboard_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear. Holds at all-ones.
//   clk, reset : clock, asynchronous active-high reset
//   clear      : synchronous clear to zero (wins over inc)
//   inc        : add one this clock
//   count      : current value (CNT_W bits, CNT_W <= SCB_MAX_W)
// -----------------------------------------------------------------------------
module sat_counter
  import wire_scoreboard_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values of its neighbours, independent of evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      count <= '0;
    else if (clear) count <= '0;
    else if (inc)   count <= CNT_W'(sat_inc(SCB_MAX_W'(count), CNT_W));
  end

endmodule

// File: rtl/wire_scoreboard.sv
// -----------------------------------------------------------------------------
// wire_scoreboard
// Compares a golden reference vector against a DUT vector under a care mask
// on every accepted sample, and accumulates run statistics.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : wire_scoreboard_if.slave (stimulus in, statistics out)
// Optional feature: define SCB_PER_BIT_COUNT_EN to get one saturating
// mismatch counter per compared bit on bus.bit_errors; otherwise it is 0.
// -----------------------------------------------------------------------------
module wire_scoreboard
  import wire_scoreboard_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  wire_scoreboard_if.slave   bus
);

  scb_state_t       state;
  scb_state_t       next_state;
  logic [WIDTH-1:0] diff;
  logic             is_mismatch;
  logic             accept;
  logic             clear;

  assign diff        = (bus.ref_vec ^ bus.dut_vec) & bus.care_mask;
  assign is_mismatch = |diff;
  // A sample arriving together with start belongs to no run and is dropped.
  assign accept      = (state == SCB_RUN) && bus.sample_en && !bus.start;
  // start from IDLE can only follow reset, where statistics are already zero,
  // so clearing on every start is equivalent and simpler.
  assign clear       = bus.start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= SCB_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets a default before the case so every path assigns it
  // and no latch is inferred.
  always_comb begin
    next_state = state;
    unique case (state)
      SCB_IDLE: if (bus.start) next_state = SCB_RUN;
      SCB_RUN: begin
        if (bus.start)     next_state = SCB_RUN;
        else if (bus.stop) next_state = SCB_DONE;
      end
      SCB_DONE: if (bus.start) next_state = SCB_RUN;
      default:  next_state = SCB_IDLE;
    endcase
  end

  // Status flags are registered from next_state so they track the state
  // register exactly while still being flop outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.running         <= 1'b0;
      bus.done            <= 1'b0;
      bus.mismatch        <= 1'b0;
      bus.first_err_idx   <= '0;
      bus.first_err_valid <= 1'b0;
    end else begin
      bus.running <= (next_state == SCB_RUN);
      bus.done    <= (next_state == SCB_DONE);
      if (clear) begin
        bus.mismatch        <= 1'b0;
        bus.first_err_idx   <= '0;
        bus.first_err_valid <= 1'b0;
      end else if (accept) begin
        bus.mismatch <= is_mismatch;
        // samples still holds the pre-increment count, i.e. this sample's index.
        if (is_mismatch && !bus.first_err_valid) begin
          bus.first_err_idx   <= bus.samples;
          bus.first_err_valid <= 1'b1;
        end
      end
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_samples (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (accept),
    .count (bus.samples)
  );

  sat_counter #(.CNT_W(CNT_W)) u_errors (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .inc   (accept && is_mismatch),
    .count (bus.errors)
  );

`ifdef SCB_PER_BIT_COUNT_EN
  logic [WIDTH*CNT_W-1:0] bit_cnt;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sat_counter #(.CNT_W(CNT_W)) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (clear),
      .inc   (accept && diff[i]),
      .count (bit_cnt[i*CNT_W +: CNT_W])
    );
  end

  assign bus.bit_errors = bit_cnt;
`else
  assign bus.bit_errors = '0;
`endif

endmodule
